mem_fill_xcel: RTL and testbench
================================

# mem_fill_xcel

Memory-fill accelerator: the write-side counterpart of the accumulate accelerator. On a `go` pulse it writes `in_size` 32-bit words to consecutive word addresses starting at `in_base`. The data is an arithmetic sequence (`in_value`, `in_value+in_step`, …). It drives a valid/ready memory write port and reports completion with a one-cycle `done` pulse. It sits beside the accumulator on the same test memory, so a bench can fill a buffer and then have it summed.

## Interface
- Parameters: none; all widths are fixed as listed below.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `go`  in  1  start request; sampled only in IDLE.
- `in_base`  in  16  byte base address; bits [1:0] are forced to 0 on latch.
- `in_size`  in  7  number of words to write, 0..127.
- `in_value`  in  32  data for the first word.
- `in_step`  in  32  added to the data after each word.
- `mem_val`  out  1  write request valid.
- `mem_addr`  out  32  write byte address, `{16'b0, addr_reg}`.
- `mem_wdata`  out  32  write data.
- `mem_rdy`  in  1  memory accepts the write when `mem_val && mem_rdy`.
- `busy`  out  1  high in WRITE and DONE.
- `done`  out  1  one-cycle pulse at completion.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - Outputs: `mem_val=0`, `busy=0`, `done=0`.
  - On `go=1`, latch `addr_reg=in_base & ~3`, `data_reg=in_value`, `step_reg=in_step`, `rem_reg=in_size`.
  - Next state is WRITE if `in_size!=0`, else DONE.
- WRITE:
  - Outputs: `mem_val=1`, `mem_addr={16'b0,addr_reg}`, `mem_wdata=data_reg`.
  - A transfer occurs on each cycle with `mem_rdy=1`. On a transfer: `addr_reg+=4` (mod 2^16), `data_reg+=step_reg` (mod 2^32, carry discarded), `rem_reg-=1`.
  - A transfer with `rem_reg==1` moves to DONE.
  - While `mem_rdy=0`, all registers and outputs hold stable.
- DONE:
  - Outputs: `done=1`, `mem_val=0`, `busy=1`.
  - Unconditionally returns to IDLE.
- `go` outside IDLE is ignored; it is not queued.
- Input ports are read only on the accepting `go` cycle. Later changes to them have no effect.
- Address wrap: 0xFFFC + 4 → 0x0000; `mem_addr[31:16]` is always 0.

## Timing
- Reset values (async, immediate): state=IDLE, all registers 0, `mem_val=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `done=0`.
- Reset mid-operation: `mem_val` drops the same instant. Writes already completed stand, and no further writes occur. The first `go` after reset release starts normally.
- All outputs are Moore outputs (state/register driven); there is no combinational path from `mem_rdy` or `go` to any output.
- `go` accepted at edge 0:
  - `mem_val=1` from cycle 1.
  - With `mem_rdy` held at 1, N words occupy cycles 1..N and `done` pulses in cycle N+1.
  - Each `mem_rdy=0` cycle in WRITE adds exactly one cycle.
- Size 0: `done` pulses in cycle 1 with no `mem_val`.
- Back-to-back runs: the earliest a new `go` is accepted is the cycle after `done`.

## Structure
- Shared package `mem_fill_xcel_pkg` holds:
  - typedef enum `fill_state_t` {IDLE, WRITE, DONE};
  - `FILL_ADDR_INCR=16'd4`.
- Sub-module `mem_fill_xcel_dpath` holds `addr_reg`/`data_reg`/`step_reg`/`rem_reg`, the two adders and the `rem_reg==1` compare.
  - Controls in: `load`, `advance`.
  - Status out: `last`.
- The FSM lives in the top module.

## Test plan
- Reset, then `go` with base 0x0100, size 4, value 5, step 3, `mem_rdy=1` → writes (0x100,5), (0x104,8), (0x108,11), (0x10C,14) in cycles 1–4; `done` in cycle 5; `busy` high cycles 1–5.
- `go` with size 0 → no `mem_val`; `done` in cycle 1; back in IDLE in cycle 2.
- Base 0x0200, size 3, `mem_rdy=0` for 2 cycles on word 2 → addr 0x204 and its data held stable through the stall; 3 writes complete by cycle 5; `done` in cycle 6.
- Base 0xFFF8, size 3, value 0xFFFFFFFF, step 1 → addrs 0xFFF8, 0xFFFC, 0x0000 with data 0xFFFFFFFF, 0x0, 0x1.
- Base 0x0103 → first addr 0x0100. A second `go` during WRITE is ignored: the write count is unchanged and there is exactly one `done`.
- Drive `rst` low after the 2nd of 4 writes → `mem_val`/`busy` go 0 immediately, no further writes, no `done`. After release, a new `go` (size 1) writes correctly.

Source files
------------

// File: rtl/mem_fill_xcel_pkg.sv
// Shared types and constants for the memory-fill accelerator.
package mem_fill_xcel_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } fill_state_t;

    // Byte distance between consecutive 32-bit words.
    localparam logic [15:0] FILL_ADDR_INCR = 16'd4;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return {addr[15:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_fill_xcel_if.sv
// Memory write port shared by the fill accelerator and the test memory.
//
// Handshake: the master raises mem_val with mem_addr/mem_wdata stable and
// holds all three unchanged until a cycle in which mem_rdy is also high.
// A write is transferred on every rising edge where mem_val && mem_rdy.
// The slave may drive mem_rdy independently of mem_val.
interface mem_fill_xcel_if;
    logic        mem_val;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;

    modport master (
        output mem_val,
        output mem_addr,
        output mem_wdata,
        input  mem_rdy
    );

    modport slave (
        input  mem_val,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdy
    );
endinterface

// File: rtl/mem_fill_xcel_dpath.sv
// Datapath for the fill accelerator: address, data, step and remaining-count
// registers plus the increment logic and the last-word compare.
module mem_fill_xcel_dpath
    import mem_fill_xcel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] in_base,
    input  logic [6:0]  in_size,
    input  logic [31:0] in_value,
    input  logic [31:0] in_step,
    output logic [15:0] addr,
    output logic [31:0] data,
    output logic        last
);

    logic [15:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] step_reg;
    logic [6:0]  rem_reg;

    // Latch a new command on load, otherwise step to the next word on advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= '0;
            data_reg <= '0;
            step_reg <= '0;
            rem_reg  <= '0;
        end else if (load) begin
            addr_reg <= word_align(in_base);
            data_reg <= in_value;
            step_reg <= in_step;
            rem_reg  <= in_size;
        end else if (advance) begin
            // Both adders wrap naturally at their register width.
            addr_reg <= addr_reg + FILL_ADDR_INCR;
            data_reg <= data_reg + step_reg;
            rem_reg  <= rem_reg - 7'd1;
        end
    end

    assign addr = addr_reg;
    assign data = data_reg;
    assign last = (rem_reg == 7'd1);

endmodule

// File: rtl/mem_fill_xcel.sv
// Memory-fill accelerator: on go, writes in_size words of an arithmetic
// sequence to consecutive word addresses and pulses done when finished.
module mem_fill_xcel
    import mem_fill_xcel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [15:0]         in_base,
    input  logic [6:0]          in_size,
    input  logic [31:0]         in_value,
    input  logic [31:0]         in_step,
    mem_fill_xcel_if.master     mem,
    output logic                busy,
    output logic                done,
    output fill_state_t         dbg_state
);

    fill_state_t state;
    logic        mem_val_q;
    logic        load;
    logic        advance;
    logic        last;
    logic [15:0] addr;
    logic [31:0] data;

    // A command is taken only in IDLE; a word moves only on a handshake.
    assign load    = (state == IDLE) && go;
    assign advance = (state == WRITE) && mem.mem_rdy;

    mem_fill_xcel_dpath u_dpath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .in_base  (in_base),
        .in_size  (in_size),
        .in_value (in_value),
        .in_step  (in_step),
        .addr     (addr),
        .data     (data),
        .last     (last)
    );

    // Control FSM with registered mem_val/busy/done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_val_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        busy <= 1'b1;
                        if (in_size != 7'd0) begin
                            state     <= WRITE;
                            mem_val_q <= 1'b1;
                        end else begin
                            // Empty command completes without any write.
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_rdy && last) begin
                        state     <= DONE;
                        mem_val_q <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_val_q <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_val   = mem_val_q;
    assign mem.mem_addr  = {16'b0, addr};
    assign mem.mem_wdata = data;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_fill_xcel.sv
// Directed bench for mem_fill_xcel.
module tb_mem_fill_xcel;
    import mem_fill_xcel_pkg::*;

    logic        clk;
    logic        rst;
    logic        go;
    logic [15:0] in_base;
    logic [6:0]  in_size;
    logic [31:0] in_value;
    logic [31:0] in_step;
    logic        busy;
    logic        done;
    fill_state_t dbg_state;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];

    mem_fill_xcel_if mif ();

    mem_fill_xcel dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .in_base   (in_base),
        .in_size   (in_size),
        .in_value  (in_value),
        .in_step   (in_step),
        .mem       (mif.master),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write and done monitors
    always @(posedge clk) begin
        if (rst && mif.mem_val && mif.mem_rdy)
            act_q.push_back({mif.mem_addr, mif.mem_wdata});
        if (rst && done)
            done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [15:0] b, input logic [6:0] s,
                             input logic [31:0] v, input logic [31:0] st);
        go = 1'b1; in_base = b; in_size = s; in_value = v; in_step = st;
        step();
        go = 1'b0;
        // Later input changes must not matter.
        in_base = 16'hAAAA; in_size = 7'd99; in_value = 32'h5555_5555; in_step = 32'h1234;
    endtask

    task automatic test_reset();
        rst = 1'b0; go = 1'b0; in_base = '0; in_size = '0; in_value = '0; in_step = '0;
        mif.mem_rdy = 1'b1;
        step(); step();
        checks++;
        if (mif.mem_val !== 1'b0 || mif.mem_addr !== 32'h0 || mif.mem_wdata !== 32'h0 ||
            busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_values: val=%b addr=%h data=%h busy=%b done=%b st=%0d, want all 0",
                     mif.mem_val, mif.mem_addr, mif.mem_wdata, busy, done, dbg_state);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        act_q.delete(); exp_q.delete();
        exp_q.push_back({32'h100, 32'd5});
        exp_q.push_back({32'h104, 32'd8});
        exp_q.push_back({32'h108, 32'd11});
        exp_q.push_back({32'h10C, 32'd14});
        mif.mem_rdy = 1'b1;
        start_cmd(16'h0100, 7'd4, 32'd5, 32'd3);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (mif.mem_val !== 1'b1 || {mif.mem_addr, mif.mem_wdata} !== exp_q[c-1] ||
                busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_cycle%0d: val=%b addr/data=%h busy=%b done=%b, want val=1 %h busy=1 done=0",
                         c, mif.mem_val, {mif.mem_addr, mif.mem_wdata}, busy, done, exp_q[c-1]);
            end
            step();
        end
        checks++;
        if (mif.mem_val !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: val=%b done=%b busy=%b, want 0 1 1", mif.mem_val, done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL basic_idle: done=%b busy=%b st=%0d, want 0 0 IDLE", done, busy, dbg_state);
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d writes, want %0d", act_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: got %h, want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_size_zero();
        act_q.delete();
        start_cmd(16'h0040, 7'd0, 32'd1, 32'd1);
        checks++;
        if (mif.mem_val !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: val=%b done=%b busy=%b, want 0 1 1", mif.mem_val, done, busy);
        end
        step();
        checks++;
        if (dbg_state !== IDLE || done !== 1'b0 || busy !== 1'b0 || mif.mem_val !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: st=%0d done=%b busy=%b val=%b, want IDLE 0 0 0",
                     dbg_state, done, busy, mif.mem_val);
        end
        checks++;
        if (act_q.size() != 0) begin
            errors++;
            $display("FAIL zero_writes: got %0d writes, want 0", act_q.size());
        end
    endtask

    task automatic test_stall();
        logic rdy_pat [1:5];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        act_q.delete(); exp_q.delete();
        exp_q.push_back({32'h200, 32'd10});
        exp_q.push_back({32'h204, 32'd12});
        exp_q.push_back({32'h208, 32'd14});
        start_cmd(16'h0200, 7'd3, 32'd10, 32'd2);
        for (int c = 1; c <= 5; c++) begin
            mif.mem_rdy = rdy_pat[c];
            if (c == 2 || c == 3 || c == 4) begin
                checks++;
                if (mif.mem_val !== 1'b1 || mif.mem_addr !== 32'h204 || mif.mem_wdata !== 32'd12) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d: val=%b addr=%h data=%h, want 1 00000204 0000000c",
                             c, mif.mem_val, mif.mem_addr, mif.mem_wdata);
                end
            end
            step();
        end
        mif.mem_rdy = 1'b1;
        checks++;
        if (act_q.size() != 3 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: writes=%0d done=%b at cycle 6, want 3 1", act_q.size(), done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stall_write%0d: got %h, want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
        step();
    endtask

    task automatic test_wrap();
        act_q.delete(); exp_q.delete();
        exp_q.push_back({32'h0000FFF8, 32'hFFFF_FFFF});
        exp_q.push_back({32'h0000FFFC, 32'h0000_0000});
        exp_q.push_back({32'h00000000, 32'h0000_0001});
        mif.mem_rdy = 1'b1;
        start_cmd(16'hFFF8, 7'd3, 32'hFFFF_FFFF, 32'd1);
        step(); step(); step(); step();
        checks++;
        if (act_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes, want 3", act_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL wrap_write%0d: got %h, want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_align_ignore_go();
        int d0;
        act_q.delete(); exp_q.delete();
        exp_q.push_back({32'h100, 32'h07});
        exp_q.push_back({32'h104, 32'h17});
        exp_q.push_back({32'h108, 32'h27});
        d0 = done_cnt;
        mif.mem_rdy = 1'b1;
        start_cmd(16'h0103, 7'd3, 32'h7, 32'h10);
        checks++;
        if (mif.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL align_first_addr: got %h, want 00000100", mif.mem_addr);
        end
        step();
        // second go while writing
        go = 1'b1; in_base = 16'h0500; in_size = 7'd5; in_value = '0; in_step = '0;
        step();
        go = 1'b0;
        for (int c = 3; c <= 7; c++) step();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ignore_go_done: got %0d done pulses, want 1", done_cnt - d0);
        end
        checks++;
        if (act_q.size() != 3) begin
            errors++;
            $display("FAIL ignore_go_count: got %0d writes, want 3", act_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL align_write%0d: got %h, want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        act_q.delete(); exp_q.delete();
        d0 = done_cnt;
        mif.mem_rdy = 1'b1;
        start_cmd(16'h0300, 7'd4, 32'd1, 32'd1);
        step(); step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mif.mem_val !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mif.mem_addr !== 32'h0 ||
            dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_outputs: val=%b busy=%b done=%b addr=%h st=%0d, want 0 0 0 0 IDLE",
                     mif.mem_val, busy, done, mif.mem_addr, dbg_state);
        end
        step(); step();
        @(negedge clk);
        rst = 1'b1;
        step(); step();
        checks++;
        if (act_q.size() != 2 || done_cnt != d0 || mif.mem_val !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_writes: writes=%0d dones=%0d val=%b, want 2 0 0",
                     act_q.size(), done_cnt - d0, mif.mem_val);
        end else begin
            checks++;
            if (act_q[0] !== {32'h300, 32'd1} || act_q[1] !== {32'h304, 32'd2}) begin
                errors++;
                $display("FAIL rst_mid_data: got %h %h, want 0000030000000001 0000030400000002",
                         act_q[0], act_q[1]);
            end
        end
        act_q.delete();
        start_cmd(16'h0040, 7'd1, 32'hAB, 32'd9);
        checks++;
        if (mif.mem_val !== 1'b1 || mif.mem_addr !== 32'h40 || mif.mem_wdata !== 32'hAB) begin
            errors++;
            $display("FAIL rst_after_write: val=%b addr=%h data=%h, want 1 00000040 000000ab",
                     mif.mem_val, mif.mem_addr, mif.mem_wdata);
        end
        step();
        checks++;
        if (done !== 1'b1 || act_q.size() != 1) begin
            errors++;
            $display("FAIL rst_after_done: done=%b writes=%0d, want 1 1", done, act_q.size());
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_stall();
        test_wrap();
        test_align_ignore_go();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
